pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// - Central stall/flush/forward controller for the 5-stage RV32I pipeline.
// - Drives the enable/clear pins of the f_d, d_e, e_m and m_w pipeline registers.
// - Detects RAW forwarding, load-use and taken-branch hazards; freezes the pipe on a
//   multi-cycle data-memory access via a wait FSM with timeout; counts stall cycles.
// PARAMETERS
// - MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before a fatal mem error (>=2)
// - CNT_W        32  width of the stall_cycles performance counter
// PORTS
// - clk           in   1   rising-edge clock, single clock domain
// - rst_n         in   1   synchronous active-low reset
// - rs1_d,rs2_d   in   5   source regs of instr in Decode
// - rs1_e,rs2_e   in   5   source regs of instr in Execute
// - rd_e          in   5   dest reg in Execute
// - ResultSrc_e0  in   1   Execute instr is a load (ResultSrc_e[0])
// - PCSrc_e       in   1   taken branch/jump resolved in Execute
// - rd_m, rd_w    in   5   dest regs in Memory / Writeback
// - RegWrite_m/_w in   1   regwrite flags in Memory / Writeback
// - MemReq_m      in   1   Memory-stage instr accesses dmem this cycle
// - mem_ready     in   1   dmem completes the access this cycle
// - ForwardA_e    out  2   00 regfile, 10 ALUResult_m, 01 Result_w
// - ForwardB_e    out  2   same encoding for rs2_e
// - stall_f       out  1   hold PC (1 = hold)
// - stall_d       out  1   hold f_d register
// - flush_d       out  1   clear f_d register
// - flush_e       out  1   clear d_e register
// - en_e_m        out  1   enable e_m register
// - en_m_w        out  1   enable m_w register
// - mem_err       out  1   sticky: dmem timeout occurred, pipe halted
// - stall_cycles  out  CNT_W  cycles with stall_f==1 (wraps)
// BEHAVIOUR
// - Forwarding is combinational. ForwardA_e=10 if RegWrite_m && rd_m!=0 && rd_m==rs1_e;
//   else 01 if RegWrite_w && rd_w!=0 && rd_w==rs1_e; else 00. M beats W; x0 is never
//   forwarded. ForwardB_e is identical on rs2_e.
// - lw_stall = ResultSrc_e0 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
// - FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN, wait_cnt=0, mem_err=0, stall_cycles=0.
// - mem_stall = (RUN && MemReq_m && !mem_ready) || MEM_WAIT || HALT.
// - RUN: MemReq_m && !mem_ready -> MEM_WAIT, wait_cnt<=1. Otherwise stay in RUN.
// - MEM_WAIT, mem_ready=1: the access completes this cycle and the pipe still holds.
//   Next state RUN, wait_cnt<=0; the pipe advances on the following cycle.
// - MEM_WAIT, mem_ready=0:
//   - wait_cnt==MEM_TIMEOUT-1 -> HALT, mem_err<=1.
//   - otherwise wait_cnt<=wait_cnt+1.
// - HALT: absorbing until rst_n=0. mem_err stays 1; mem_ready is ignored.
// - Output priority, highest first:
//   1 mem_stall: stall_f=stall_d=1, en_e_m=en_m_w=0, flush_d=flush_e=0 (whole pipe frozen;
//     the W instr re-writes the regfile, which is harmless).
//   2 PCSrc_e: flush_d=flush_e=1, stall_f=stall_d=0, en_e_m=en_m_w=1 (a taken branch
//     overrides a simultaneous lw_stall).
//   3 lw_stall: stall_f=stall_d=1, flush_e=1, flush_d=0, en_e_m=en_m_w=1.
//   4 none: stall_f=stall_d=flush_d=flush_e=0, en_e_m=en_m_w=1.
// - While rst_n=0: all stall/flush outputs are 0, en_e_m=en_m_w=1, and the FSM is
//   forced to RUN. Reset mid-MEM_WAIT or in HALT returns to RUN on the next edge.
// - stall_cycles increments on each posedge where rst_n=1 and stall_f=1; it wraps
//   modulo 2^CNT_W.
// - No combinational path from any output back to any input.
// TESTING
// - Forwarding: rd_m=5, RegWrite_m=1, rd_w=5, RegWrite_w=1, rs1_e=5 -> ForwardA_e=10;
//   same with rd_m=0 -> 01; rs2_e=0, rd_w=0 -> ForwardB_e=00.
// - Load-use: ResultSrc_e0=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle;
//   stall_cycles +1.
// - Branch vs load-use: lw_stall and PCSrc_e=1 together -> flush_d=flush_e=1,
//   stall_f=stall_d=0.
// - Mem wait: MemReq_m=1, mem_ready low 3 cycles then high -> en_e_m=en_m_w=0 for
//   4 cycles, then RUN; stall_cycles +4.
// - Timeout: MemReq_m=1, mem_ready=0 forever -> HALT after MEM_TIMEOUT cycles; mem_err=1
//   sticky; rst_n low 1 cycle -> RUN, mem_err=0.
// - Branch during mem stall: PCSrc_e=1 while in MEM_WAIT -> flush_d=flush_e=0 until the
//   FSM is back in RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle for the 5-stage RV32I pipeline.
// master: pipeline datapath side. It drives register indices, stage flags and
//         the dmem handshake, and it receives the forwarding selects and the
//         stall/flush/enable pins.
// slave : the hazard controller. It sees the same signals in the opposite
//         directions.
// Inputs to the controller:
//   rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
//   ResultSrc_e0, PCSrc_e, RegWrite_m, RegWrite_w, MemReq_m, mem_ready.
// Outputs from the controller:
//   ForwardA_e, ForwardB_e, stall_f, stall_d, flush_d, flush_e,
//   en_e_m, en_m_w, mem_err, stall_cycles.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             ResultSrc_e0, PCSrc_e, RegWrite_m, RegWrite_w;
  logic             MemReq_m, mem_ready;
  logic [1:0]       ForwardA_e, ForwardB_e;
  logic             stall_f, stall_d, flush_d, flush_e, en_e_m, en_m_w, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           ResultSrc_e0, PCSrc_e, RegWrite_m, RegWrite_w, MemReq_m, mem_ready,
    input  ForwardA_e, ForwardB_e, stall_f, stall_d, flush_d, flush_e,
           en_e_m, en_m_w, mem_err, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           ResultSrc_e0, PCSrc_e, RegWrite_m, RegWrite_w, MemReq_m, mem_ready,
    output ForwardA_e, ForwardB_e, stall_f, stall_d, flush_d, flush_e,
           en_e_m, en_m_w, mem_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage RV32I pipeline.
// Responsibilities:
//   - Resolves RAW hazards by forwarding, with the M stage taking priority over W.
//   - Inserts a one-cycle bubble on a load-use hazard.
//   - Flushes F/D and D/E when a branch is taken.
//   - Freezes the whole pipe during a multi-cycle dmem access. If the wait lasts
//     MEM_TIMEOUT cycles, the controller halts with a sticky mem_err.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave modport of pipeline_hazard_ctrl_if. It carries the stage
//          register indices and flags, the dmem handshake, the forwarding
//          selects, the stall/flush/enable pins, mem_err and stall_cycles.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_err_q, mem_err_nxt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              lw_stall, mem_stall;
  logic              stall_f, stall_d, flush_d, flush_e, en_e_m, en_m_w;

  // x0 is hardwired to zero, so it is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] dst_m, input logic wr_m,
                                         input logic [4:0] dst_w, input logic wr_w);
    if (wr_m && (dst_m != 5'd0) && (dst_m == rs)) return 2'b10;
    if (wr_w && (dst_w != 5'd0) && (dst_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign bus.ForwardA_e = fwd_sel(bus.rs1_e, bus.rd_m, bus.RegWrite_m, bus.rd_w, bus.RegWrite_w);
  assign bus.ForwardB_e = fwd_sel(bus.rs2_e, bus.rd_m, bus.RegWrite_m, bus.rd_w, bus.RegWrite_w);

  assign lw_stall = bus.ResultSrc_e0 && (bus.rd_e != 5'd0) &&
                    ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err_q;
    mem_stall    = 1'b0;
    case (state)
      RUN: begin
        // The first cycle of a slow access already freezes the pipe.
        if (bus.MemReq_m && !bus.mem_ready) begin
          mem_stall    = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // The completing cycle still holds the pipe. It advances one cycle later.
        mem_stall = 1'b1;
        if (bus.mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = HALT;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        end
      end
      HALT:    mem_stall = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // Priority order: frozen pipe > taken branch > load-use bubble > free run.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    en_e_m  = 1'b1;
    en_m_w  = 1'b1;
    if (rst_n) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        en_e_m  = 1'b0;
        en_m_w  = 1'b0;
      end else if (bus.PCSrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_err_q <= mem_err_nxt;
      if (stall_f) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_f      = stall_f;
  assign bus.stall_d      = stall_d;
  assign bus.flush_d      = flush_d;
  assign bus.flush_e      = flush_e;
  assign bus.en_e_m       = en_e_m;
  assign bus.en_m_w       = en_m_w;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run. Outputs are compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // {stall_f, stall_d, flush_d, flush_e, en_e_m, en_m_w}
  logic [5:0] ctrl_v;
  assign ctrl_v = {bus.stall_f, bus.stall_d, bus.flush_d, bus.flush_e, bus.en_e_m, bus.en_m_w};

  localparam logic [5:0] C_FREEZE = 6'b110000;
  localparam logic [5:0] C_BRANCH = 6'b001111;
  localparam logic [5:0] C_LOADUSE = 6'b110111;
  localparam logic [5:0] C_FREE   = 6'b000011;

  // Behavioural model of the memory-wait bookkeeping.
  // m_waiting: an access is outstanding.
  // m_waited:  cycles spent on it so far, counting the initial request cycle.
  bit          m_waiting = 0;
  int          m_waited  = 0;
  bit          m_halted  = 0;
  bit          m_err     = 0;
  logic [31:0] m_stalls  = '0;

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (bus.RegWrite_m && bus.rd_m == rs) return 2'b10;
    if (bus.RegWrite_w && bus.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [5:0] model_ctrl();
    bit frozen, loaduse;
    if (!rst_n) return C_FREE;
    frozen  = m_waiting || m_halted || (bus.MemReq_m && !bus.mem_ready);
    loaduse = bus.ResultSrc_e0 && bus.rd_e != 0 && (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
    if (frozen) return C_FREEZE;
    if (bus.PCSrc_e) return C_BRANCH;
    if (loaduse) return C_LOADUSE;
    return C_FREE;
  endfunction

  always @(posedge clk) begin : model_step
    logic [5:0] c;
    c = model_ctrl();
    if (!rst_n) begin
      m_waiting = 0; m_waited = 0; m_halted = 0; m_err = 0; m_stalls = '0;
    end else begin
      if (c[5]) m_stalls = m_stalls + 32'd1;
      if (!m_halted) begin
        if (m_waiting) begin
          if (bus.mem_ready) begin
            m_waiting = 0;
            m_waited  = 0;
          end else if (m_waited + 1 >= MEM_TIMEOUT) begin
            m_waiting = 0;
            m_halted  = 1;
            m_err     = 1;
          end else begin
            m_waited++;
          end
        end else if (bus.MemReq_m && !bus.mem_ready) begin
          m_waiting = 1;
          m_waited  = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rs1_e = 0; bus.rs2_e = 0;
    bus.rd_e = 0; bus.rd_m = 0; bus.rd_w = 0;
    bus.ResultSrc_e0 = 0; bus.PCSrc_e = 0; bus.RegWrite_m = 0; bus.RegWrite_w = 0;
    bus.MemReq_m = 0; bus.mem_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    bus.MemReq_m = 1; bus.PCSrc_e = 1; bus.ResultSrc_e0 = 1; bus.rd_e = 3; bus.rs1_d = 3;
    cyc();
    cyc();
    #1;
    total++;
    if (ctrl_v !== C_FREE) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl_v, C_FREE); end
    total++;
    if (bus.stall_cycles !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.stall_cycles); end
    total++;
    if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.mem_err); end
    idle();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_forwarding();
    idle();
    bus.rd_m = 5; bus.RegWrite_m = 1; bus.rd_w = 5; bus.RegWrite_w = 1; bus.rs1_e = 5;
    #1;
    total++;
    if (bus.ForwardA_e !== 2'b10) begin bad++; $display("FAIL fwd_m_beats_w got=%b want=10", bus.ForwardA_e); end
    bus.rd_m = 0;
    #1;
    total++;
    if (bus.ForwardA_e !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b want=01", bus.ForwardA_e); end
    bus.rs2_e = 0; bus.rd_w = 0;
    #1;
    total++;
    if (bus.ForwardB_e !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b want=00", bus.ForwardB_e); end
    for (int i = 0; i < 24; i++) begin
      bus.rs1_e = 5'($urandom_range(0, 3)); bus.rs2_e = 5'($urandom_range(0, 3));
      bus.rd_m = 5'($urandom_range(0, 3)); bus.rd_w = 5'($urandom_range(0, 3));
      bus.RegWrite_m = 1'($urandom); bus.RegWrite_w = 1'($urandom);
      #1;
      total++;
      if ({bus.ForwardA_e, bus.ForwardB_e} !== {model_fwd(bus.rs1_e), model_fwd(bus.rs2_e)}) begin
        bad++;
        $display("FAIL fwd_rand got=%b%b want=%b%b", bus.ForwardA_e, bus.ForwardB_e,
                 model_fwd(bus.rs1_e), model_fwd(bus.rs2_e));
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    idle();
    #1;
    base = m_stalls;
    bus.ResultSrc_e0 = 1; bus.rd_e = 7; bus.rs2_d = 7; bus.rs1_d = 2;
    #1;
    total++;
    if (ctrl_v !== C_LOADUSE) begin bad++; $display("FAIL load_use_ctrl got=%b want=%b", ctrl_v, C_LOADUSE); end
    cyc();
    idle();
    #1;
    total++;
    if (ctrl_v !== C_FREE) begin bad++; $display("FAIL load_use_release got=%b want=%b", ctrl_v, C_FREE); end
    total++;
    if (bus.stall_cycles !== base + 32'd1) begin
      bad++; $display("FAIL load_use_cnt got=%0d want=%0d", bus.stall_cycles, base + 32'd1);
    end
    // A load writing x0 never causes a bubble.
    bus.ResultSrc_e0 = 1; bus.rd_e = 0; bus.rs1_d = 0;
    #1;
    total++;
    if (ctrl_v !== C_FREE) begin bad++; $display("FAIL load_use_x0 got=%b want=%b", ctrl_v, C_FREE); end
    idle();
    cyc();
  endtask

  task automatic test_branch_vs_lw();
    idle();
    bus.ResultSrc_e0 = 1; bus.rd_e = 9; bus.rs1_d = 9; bus.PCSrc_e = 1;
    #1;
    total++;
    if (ctrl_v !== C_BRANCH) begin bad++; $display("FAIL branch_vs_lw got=%b want=%b", ctrl_v, C_BRANCH); end
    cyc();
    idle();
    cyc();
  endtask

  task automatic test_mem_wait();
    logic [31:0] base;
    idle();
    #1;
    base = m_stalls;
    bus.MemReq_m = 1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      #1;
      total++;
      if (ctrl_v !== C_FREEZE) begin bad++; $display("FAIL mem_wait_cyc%0d got=%b want=%b", i, ctrl_v, C_FREEZE); end
      cyc();
    end
    idle();
    #1;
    total++;
    if (ctrl_v !== C_FREE) begin bad++; $display("FAIL mem_wait_done got=%b want=%b", ctrl_v, C_FREE); end
    total++;
    if (bus.stall_cycles !== base + 32'd4) begin
      bad++; $display("FAIL mem_wait_cnt got=%0d want=%0d", bus.stall_cycles, base + 32'd4);
    end
    cyc();
  endtask

  task automatic test_timeout();
    idle();
    bus.MemReq_m = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      total++;
      if (bus.mem_err !== 1'b0) begin bad++; $display("FAIL timeout_early_err cyc=%0d got=%b want=0", i, bus.mem_err); end
      cyc();
    end
    #1;
    total++;
    if (bus.mem_err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", bus.mem_err); end
    // HALT ignores a late mem_ready and the request going away.
    bus.MemReq_m = 0; bus.mem_ready = 1; bus.PCSrc_e = 1;
    cyc(); cyc();
    #1;
    total++;
    if ({bus.mem_err, ctrl_v} !== {1'b1, C_FREEZE}) begin
      bad++; $display("FAIL halt_sticky got=%b%b want=1%b", bus.mem_err, ctrl_v, C_FREEZE);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ctrl_v !== C_FREE) begin bad++; $display("FAIL halt_in_reset got=%b want=%b", ctrl_v, C_FREE); end
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    total++;
    if ({bus.mem_err, ctrl_v, bus.stall_cycles} !== {1'b0, C_FREE, 32'd0}) begin
      bad++; $display("FAIL halt_recover got err=%b ctrl=%b cnt=%0d want err=0 ctrl=%b cnt=0",
                      bus.mem_err, ctrl_v, bus.stall_cycles, C_FREE);
    end
    cyc();
  endtask

  task automatic test_branch_during_mem();
    idle();
    bus.MemReq_m = 1;
    cyc();
    bus.MemReq_m = 0; bus.PCSrc_e = 1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 2);
      #1;
      total++;
      if (ctrl_v !== C_FREEZE) begin bad++; $display("FAIL branch_in_wait cyc=%0d got=%b want=%b", i, ctrl_v, C_FREEZE); end
      cyc();
    end
    bus.mem_ready = 0;
    #1;
    total++;
    if (ctrl_v !== C_BRANCH) begin bad++; $display("FAIL branch_after_wait got=%b want=%b", ctrl_v, C_BRANCH); end
    idle();
    cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      bus.rs1_d = 5'($urandom_range(0, 3)); bus.rs2_d = 5'($urandom_range(0, 3));
      bus.rs1_e = 5'($urandom_range(0, 3)); bus.rs2_e = 5'($urandom_range(0, 3));
      bus.rd_e = 5'($urandom_range(0, 3)); bus.rd_m = 5'($urandom_range(0, 3));
      bus.rd_w = 5'($urandom_range(0, 3));
      bus.ResultSrc_e0 = 1'($urandom); bus.PCSrc_e = ($urandom_range(0, 3) == 0);
      bus.RegWrite_m = 1'($urandom); bus.RegWrite_w = 1'($urandom);
      bus.MemReq_m = ($urandom_range(0, 3) == 0);
      bus.mem_ready = ($urandom_range(0, 2) == 0);
      #1;
      total++;
      if (ctrl_v !== model_ctrl()) begin bad++; $display("FAIL rand_ctrl n=%0d got=%b want=%b", n, ctrl_v, model_ctrl()); end
      total++;
      if ({bus.ForwardA_e, bus.ForwardB_e} !== {model_fwd(bus.rs1_e), model_fwd(bus.rs2_e)}) begin
        bad++; $display("FAIL rand_fwd n=%0d got=%b%b", n, bus.ForwardA_e, bus.ForwardB_e);
      end
      total++;
      if (bus.mem_err !== m_err) begin bad++; $display("FAIL rand_err n=%0d got=%b want=%b", n, bus.mem_err, m_err); end
      total++;
      if (bus.stall_cycles !== m_stalls) begin
        bad++; $display("FAIL rand_cnt n=%0d got=%0d want=%0d", n, bus.stall_cycles, m_stalls);
      end
      cyc();
    end
    rst_n = 1'b1;
    idle();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lw();
    test_mem_wait();
    test_timeout();
    test_branch_during_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
